// File: rtl/character_anim_ctrl.sv
// Per-character action/animation controller: turns player and collision inputs into an
// action state, a sprite frame index and movement pulses, all paced by the frame strobe.
module character_anim_ctrl #(
  parameter int FRAME_W       = 8,
  parameter int DELAY_W       = 8,
  parameter int STAND_FRAMES  = 8,
  parameter int STAND_DELAY   = 10,
  parameter int MOVE_FRAMES   = 4,
  parameter int MOVE_DELAY    = 10,
  parameter int ATK_FRAMES    = 9,
  parameter int ATK_DELAY     = 3,
  parameter int ATK_HIT_FRAME = 5,
  parameter int HURT_FRAMES   = 4,
  parameter int HURT_DELAY    = 10,
  parameter int DEF_FRAMES    = 1,
  parameter int DEF_DELAY     = 3,
  parameter int COMBO_WIN     = 3,
  parameter int MAX_COMBO     = 3,
  parameter int INVULN_TICKS  = 30
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               attack,
  input  logic               defend,
  input  logic               move_r,
  input  logic               move_l,
  input  logic               hurt,
  output logic [2:0]         state_out,
  output logic [FRAME_W-1:0] frame_num,
  output logic [1:0]         combo_idx,
  output logic               move_r_o,
  output logic               move_l_o,
  output logic               facing_l,
  output logic               invuln,
  output logic               hit_active,
  output logic               blocked
);

  localparam int INV_W = (INVULN_TICKS > 0) ? $clog2(INVULN_TICKS + 1) : 1;

  localparam logic [FRAME_W-1:0] STAND_LAST = FRAME_W'(STAND_FRAMES - 1);
  localparam logic [FRAME_W-1:0] MOVE_LAST  = FRAME_W'(MOVE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] ATK_LAST   = FRAME_W'(ATK_FRAMES - 1);
  localparam logic [FRAME_W-1:0] HURT_LAST  = FRAME_W'(HURT_FRAMES - 1);
  localparam logic [FRAME_W-1:0] DEF_LAST   = FRAME_W'(DEF_FRAMES - 1);
  localparam logic [FRAME_W-1:0] HIT_FRAME  = FRAME_W'(ATK_HIT_FRAME);
  localparam logic [FRAME_W:0]   COMBO_OPEN = (FRAME_W+1)'(ATK_FRAMES - COMBO_WIN);
  localparam logic [1:0]         COMBO_LAST = 2'(MAX_COMBO - 1);
  localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INVULN_TICKS);

  if (STAND_FRAMES > (64'd1 << FRAME_W) || MOVE_FRAMES > (64'd1 << FRAME_W) ||
      ATK_FRAMES > (64'd1 << FRAME_W) || HURT_FRAMES > (64'd1 << FRAME_W) ||
      DEF_FRAMES > (64'd1 << FRAME_W)) begin : g_bad_frames
    $error("character_anim_ctrl: a *_FRAMES value does not fit FRAME_W");
  end
  if (STAND_DELAY > (64'd1 << DELAY_W) - 1 || MOVE_DELAY > (64'd1 << DELAY_W) - 1 ||
      ATK_DELAY > (64'd1 << DELAY_W) - 1 || HURT_DELAY > (64'd1 << DELAY_W) - 1 ||
      DEF_DELAY > (64'd1 << DELAY_W) - 1) begin : g_bad_delay
    $error("character_anim_ctrl: a *_DELAY value does not fit DELAY_W");
  end
  if (COMBO_WIN > ATK_FRAMES || MAX_COMBO > 4 || MAX_COMBO < 1) begin : g_bad_combo
    $error("character_anim_ctrl: illegal COMBO_WIN / MAX_COMBO");
  end

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_MOVE_R = 3'd1,
    ST_MOVE_L = 3'd2,
    ST_ATTACK = 3'd3,
    ST_HURT   = 3'd4,
    ST_DEFEND = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [FRAME_W-1:0] frame_n;
  logic [DELAY_W-1:0] delay, delay_n;
  logic [1:0]         combo_n;
  logic               combo_req, req_n;
  logic [INV_W-1:0]   inv_cnt, inv_n;
  logic               face_n, mr_n, ml_n, blk_n, restart;
  logic               frame_clk_d, tick;
  logic [FRAME_W-1:0] cur_last;
  logic [DELAY_W-1:0] cur_delay;
  logic               frame_end, hurt_ok, req_r, req_l;

  always_comb begin
    cur_last  = STAND_LAST;
    cur_delay = DELAY_W'(STAND_DELAY);
    case (state)
      ST_MOVE_R, ST_MOVE_L: begin cur_last = MOVE_LAST; cur_delay = DELAY_W'(MOVE_DELAY); end
      ST_ATTACK:            begin cur_last = ATK_LAST;  cur_delay = DELAY_W'(ATK_DELAY);  end
      ST_HURT:              begin cur_last = HURT_LAST; cur_delay = DELAY_W'(HURT_DELAY); end
      ST_DEFEND:            begin cur_last = DEF_LAST;  cur_delay = DELAY_W'(DEF_DELAY);  end
      default: ;
    endcase
  end

  assign frame_end = (delay == cur_delay) && (frame_num == cur_last);
  assign invuln    = (inv_cnt != '0);
  assign hurt_ok   = hurt & ~invuln;
  // Opposing directions cancel out into no move request.
  assign req_r     = move_r & ~move_l;
  assign req_l     = move_l & ~move_r;

  always_comb begin
    state_n = state;
    frame_n = frame_num;
    delay_n = delay;
    combo_n = combo_idx;
    req_n   = combo_req;
    face_n  = facing_l;
    inv_n   = inv_cnt;
    mr_n    = 1'b0;
    ml_n    = 1'b0;
    blk_n   = 1'b0;
    restart = 1'b0;
    if (tick) begin
      if (invuln) inv_n = inv_cnt - 1'b1;
      if (delay == cur_delay) begin
        delay_n = '0;
        frame_n = (frame_num == cur_last) ? '0 : frame_num + 1'b1;
      end else begin
        delay_n = delay + 1'b1;
      end
      case (state)
        ST_STAND: begin
          if (hurt_ok)     begin state_n = ST_HURT;   restart = 1'b1; end
          else if (attack) begin state_n = ST_ATTACK; restart = 1'b1; end
          else if (defend) begin state_n = ST_DEFEND; restart = 1'b1; end
          else if (req_r)  begin state_n = ST_MOVE_R; face_n = 1'b0; restart = 1'b1; end
          else if (req_l)  begin state_n = ST_MOVE_L; face_n = 1'b1; restart = 1'b1; end
        end
        ST_MOVE_R: begin
          if (hurt_ok)     begin state_n = ST_HURT;   restart = 1'b1; end
          else if (req_r)  mr_n = 1'b1;
          else if (attack) begin state_n = ST_ATTACK; restart = 1'b1; end
          else if (req_l)  begin state_n = ST_MOVE_L; face_n = 1'b1; restart = 1'b1; end
          else             begin state_n = ST_STAND;  restart = 1'b1; end
        end
        ST_MOVE_L: begin
          if (hurt_ok)     begin state_n = ST_HURT;   restart = 1'b1; end
          else if (req_l)  ml_n = 1'b1;
          else if (attack) begin state_n = ST_ATTACK; restart = 1'b1; end
          else if (req_r)  begin state_n = ST_MOVE_R; face_n = 1'b0; restart = 1'b1; end
          else             begin state_n = ST_STAND;  restart = 1'b1; end
        end
        ST_ATTACK: begin
          if (hurt_ok) begin
            state_n = ST_HURT;
            combo_n = '0;
            req_n   = 1'b0;
            restart = 1'b1;
          end else begin
            // A press landing on the very last tick still chains.
            if (attack && ({1'b0, frame_num} >= COMBO_OPEN)) req_n = 1'b1;
            if (frame_end) begin
              if (req_n && combo_idx < COMBO_LAST) combo_n = combo_idx + 1'b1;
              else begin state_n = ST_STAND; combo_n = '0; end
              req_n   = 1'b0;
              restart = 1'b1;
            end
          end
        end
        ST_HURT: begin
          if (frame_end) begin
            state_n = ST_STAND;
            inv_n   = INV_LOAD;
            restart = 1'b1;
          end
        end
        ST_DEFEND: begin
          blk_n = hurt;
          if (frame_end && !defend) begin state_n = ST_STAND; restart = 1'b1; end
        end
        default: begin state_n = ST_STAND; restart = 1'b1; end
      endcase
      if (restart) begin
        frame_n = '0;
        delay_n = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      // frame_clk_d starts high so a strobe held through reset is not seen as an edge.
      frame_clk_d <= 1'b1;
      tick        <= 1'b0;
      state       <= ST_STAND;
      frame_num   <= '0;
      delay       <= '0;
      combo_idx   <= '0;
      combo_req   <= 1'b0;
      inv_cnt     <= '0;
      facing_l    <= 1'b0;
      move_r_o    <= 1'b0;
      move_l_o    <= 1'b0;
      blocked     <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      tick        <= frame_clk & ~frame_clk_d;
      state       <= state_n;
      frame_num   <= frame_n;
      delay       <= delay_n;
      combo_idx   <= combo_n;
      combo_req   <= req_n;
      inv_cnt     <= inv_n;
      facing_l    <= face_n;
      move_r_o    <= mr_n;
      move_l_o    <= ml_n;
      blocked     <= blk_n;
    end
  end

  assign state_out  = state;
  assign hit_active = (state == ST_ATTACK) && (frame_num == HIT_FRAME);

endmodule

// File: tb/tb_character_anim_ctrl.sv
// Directed bench for character_anim_ctrl: frame strobes are driven one tick at a time and
// states, frames and pulse counts are compared with hand-derived values.
module tb_character_anim_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       attack = 1'b0, defend = 1'b0, move_r = 1'b0, move_l = 1'b0, hurt = 1'b0;
  logic [2:0] state_out;
  logic [7:0] frame_num;
  logic [1:0] combo_idx;
  logic       move_r_o, move_l_o, facing_l, invuln, hit_active, blocked;

  int n_tests = 0;
  int n_fail  = 0;
  int ml_cnt = 0, mr_cnt = 0, blk_cnt = 0, hit_cnt = 0;

  character_anim_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .attack     (attack),
    .defend     (defend),
    .move_r     (move_r),
    .move_l     (move_l),
    .hurt       (hurt),
    .state_out  (state_out),
    .frame_num  (frame_num),
    .combo_idx  (combo_idx),
    .move_r_o   (move_r_o),
    .move_l_o   (move_l_o),
    .facing_l   (facing_l),
    .invuln     (invuln),
    .hit_active (hit_active),
    .blocked    (blocked)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame_clk pulse per tick; pulses are sampled while they are high.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      frame_clk = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      ml_cnt  += int'(move_l_o);
      mr_cnt  += int'(move_r_o);
      blk_cnt += int'(blocked);
      hit_cnt += int'(hit_active);
      frame_clk = 1'b0;
      @(negedge Clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    chk("rst_state", state_out, 0);
    chk("rst_frame", frame_num, 0);
    chk("rst_combo", combo_idx, 0);
    chk("rst_facing", facing_l, 0);
    chk("rst_invuln", invuln, 0);
    chk("rst_pulses", {move_r_o, move_l_o, blocked, hit_active}, 0);

    // idle animation: 8 frames of 11 ticks
    step(11);  chk("idle_f1", frame_num, 1);
    step(66);  chk("idle_f7", frame_num, 7);
    step(11);  chk("idle_wrap", frame_num, 0);
    chk("idle_state", state_out, 0);

    // walk left
    move_l = 1'b1; ml_cnt = 0;
    step(1);
    chk("ml_enter", state_out, 2);
    chk("ml_facing", facing_l, 1);
    chk("ml_entry_pulse", ml_cnt, 0);
    step(11);
    chk("ml_frame", frame_num, 1);
    chk("ml_pulses", ml_cnt, 11);
    move_l = 1'b0;
    step(1);
    chk("ml_release", state_out, 0);
    chk("ml_face_hold", facing_l, 1);
    chk("ml_no_pulse", ml_cnt, 11);

    // walk right, then both directions cancel
    move_r = 1'b1; mr_cnt = 0;
    step(2);
    chk("mr_state", state_out, 1);
    chk("mr_facing", facing_l, 0);
    chk("mr_pulses", mr_cnt, 1);
    move_l = 1'b1;
    step(1);
    chk("both_stand", state_out, 0);
    chk("both_no_pulse", mr_cnt, 1);
    move_r = 1'b0; move_l = 1'b0;

    // single attack: 9 frames x 4 ticks
    attack = 1'b1; hit_cnt = 0;
    step(1);
    attack = 1'b0;
    chk("atk_enter", state_out, 3);
    step(35);
    chk("atk_last", state_out, 3);
    chk("atk_last_frame", frame_num, 8);
    step(1);
    chk("atk_done", state_out, 0);
    chk("atk_hits", hit_cnt, 4);
    chk("atk_combo", combo_idx, 0);

    // three-hit chain; the fourth press is ignored
    attack = 1'b1; hit_cnt = 0;
    step(1);
    attack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(28);
      chk("cmb_frame7", frame_num, 7);
      attack = 1'b1;
      step(1);
      attack = 1'b0;
      step(7);
      if (k < 2) begin
        chk("cmb_idx", combo_idx, k + 1);
        chk("cmb_state", state_out, 3);
        chk("cmb_frame0", frame_num, 0);
      end
    end
    chk("cmb_end_state", state_out, 0);
    chk("cmb_end_idx", combo_idx, 0);
    chk("cmb_hits", hit_cnt, 12);

    // hurt interrupts attack, then invulnerability window
    attack = 1'b1;
    step(1);
    attack = 1'b0;
    step(5);
    hurt = 1'b1;
    step(1);
    hurt = 1'b0;
    chk("hurt_enter", state_out, 4);
    chk("hurt_frame", frame_num, 0);
    step(43);
    chk("hurt_last", state_out, 4);
    step(1);
    chk("hurt_done", state_out, 0);
    chk("inv_set", invuln, 1);
    step(10);
    hurt = 1'b1;
    step(1);
    hurt = 1'b0;
    chk("inv_ignore", state_out, 0);
    step(18);
    chk("inv_still", invuln, 1);
    step(1);
    chk("inv_clear", invuln, 0);
    hurt = 1'b1;
    step(1);
    hurt = 1'b0;
    chk("inv_accept", state_out, 4);
    step(44);
    chk("hurt2_done", state_out, 0);

    // defend absorbs a hit
    defend = 1'b1; blk_cnt = 0;
    step(1);
    chk("def_enter", state_out, 5);
    hurt = 1'b1;
    step(1);
    hurt = 1'b0;
    chk("def_blocked", blk_cnt, 1);
    chk("def_stay", state_out, 5);
    chk("def_blk_low", blocked, 0);
    step(5);
    chk("def_hold", state_out, 5);
    defend = 1'b0;
    step(1);
    chk("def_frame_end", state_out, 5);
    step(1);
    chk("def_release", state_out, 0);

    // reset mid-hurt with frame_clk held high
    step(30);
    move_l = 1'b1;
    step(1);
    move_l = 1'b0;
    step(1);
    chk("pre_rst_facing", facing_l, 1);
    hurt = 1'b1;
    step(1);
    hurt = 1'b0;
    chk("pre_rst_hurt", state_out, 4);
    step(3);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    move_r = 1'b1;
    chk("rst2_state", state_out, 0);
    chk("rst2_frame", frame_num, 0);
    chk("rst2_facing", facing_l, 0);
    chk("rst2_invuln", invuln, 0);
    chk("rst2_pulses", {move_r_o, move_l_o, blocked, hit_active}, 0);
    repeat (6) @(negedge Clk);
    chk("rst2_no_tick", state_out, 0);
    frame_clk = 1'b0;
    step(1);
    chk("rst2_first_tick", state_out, 1);
    move_r = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
